systolic_output_drain: RTL
==========================

Name: systolic_output_drain

Overview:
- Downstream stage of the buffered systolic array (ternary-weight matmul-free accelerator).
- Captures one complete HIDDEN_SIZE x CONTEXT_LENGTH result matrix of 2*WIDTH-bit signed accumulators.
- Requantizes each element to WIDTH bits: rounding arithmetic right shift, then saturation.
- Streams the matrix out one row per beat over a valid/ready interface, feeding the next layer's activation buffer.

Parameters:
- WIDTH, 16, activation width; input elements are 2*WIDTH bits signed.
- HIDDEN_SIZE, 2, number of result rows (beats per matrix).
- CONTEXT_LENGTH, 4, elements per row.

Ports:
- clock  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- y_valid  in  1  Y_in holds a complete result matrix.
- y_ready  out  1  block can capture a matrix this cycle.
- Y_in  in  HIDDEN_SIZE*CONTEXT_LENGTH*2*WIDTH  packed signed matrix [HIDDEN_SIZE][CONTEXT_LENGTH][2*WIDTH].
- shift_amt  in  5  right-shift amount, sampled at capture.
- out_valid  out  1  out_data holds a valid row.
- out_ready  in  1  consumer accepts the row.
- out_data  out  CONTEXT_LENGTH*WIDTH  packed signed row [CONTEXT_LENGTH][WIDTH].
- out_row  out  max(1,$clog2(HIDDEN_SIZE))  index of the row presented.
- out_last  out  1  presented row is HIDDEN_SIZE-1.
- sat_flag  out  1  at least one element of the presented row saturated.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; out_valid=0; out_data=0; out_row=0; out_last=0; sat_flag=0.
  - Quantized buffer and per-row sat bits cleared.
  - y_ready=1 once rst deasserts.
- States:
  - IDLE: y_ready=1, out_valid=0. On y_valid&&y_ready, capture and go to DRAIN.
  - DRAIN: out_valid=1; row counter r selects the presented row.
    - On out_valid&&out_ready with r<HIDDEN_SIZE-1: r<=r+1.
    - On the last beat: go to IDLE, r<=0, unless a same-cycle capture occurs.
- Capture:
  - Every element is quantized at capture and stored in a WIDTH-bit buffer plus one sat bit per row.
  - Output path is buffer-indexed only; no combinational path from Y_in or shift_amt to any output.
- y_ready = (state==IDLE) || (out_valid && out_ready && out_last).
  - Simultaneous last-beat handshake and y_valid: new matrix captured that cycle, stays in DRAIN, r<=0.
  - New row 0 appears the next cycle; no bubble.
- Latency: capture at edge N gives out_valid=1 with row 0 after edge N (visible cycle N+1). A full matrix needs HIDDEN_SIZE accepted beats.
- Hold rule: while out_valid && !out_ready, out_data, out_row, out_last and sat_flag are stable.
  - y_valid in DRAIN is ignored (y_ready=0) except on the last-beat cycle.
- Quantization of x (signed 2*WIDTH), s=shift_amt:
  - Compute in 2*WIDTH+1 bits.
  - If s>0: t = (x + (1<<(s-1))) >>> s (round half toward +inf). If s=0: t=x.
  - Shifts of 2*WIDTH or more are legal; result is 0 or -1 per the formula.
  - Saturate t to [-(2^(WIDTH-1)), 2^(WIDTH-1)-1]. The row's sat bit = OR of element saturations.
- Reset mid-DRAIN: remaining rows discarded, out_valid drops asynchronously, no partial resume.
- HIDDEN_SIZE=1: every beat is last; out_row stays 0.

Test Plan:
- Reset: hold rst, toggle y_valid, out_ready -> all outputs 0, no capture; after release y_ready=1, out_valid=0.
- Basic drain, shift 0, out_ready=1:
  - Stimulus: Y rows [1,-2,3,-4], [100,0,-100,7].
  - Beat 1: out_row=0, data [1,-2,3,-4], out_last=0, sat_flag=0.
  - Beat 2: out_row=1, data [100,0,-100,7], out_last=1.
  - Then IDLE, y_ready=1.
- Rounding, shift_amt=4:
  - Stimulus: row0 [24,-24,8,7] -> [2,-1,1,0].
  - Stimulus: row1 [-8,-9,0,15] -> [0,-1,0,1].
- Saturation, shift 0:
  - Stimulus: row0 [40000,-40000,32767,-32768] -> [32767,-32768,32767,-32768], sat_flag=1.
  - Row1 all zeros -> sat_flag=0.
- Backpressure and back-to-back:
  - out_ready=0 for 3 cycles on row 0 -> outputs held, y_valid ignored.
  - At last-beat handshake with y_valid=1, second matrix captured.
  - Next cycle presents its row 0 with out_valid continuously high.
- Async reset mid-drain: assert rst between posedges during row 0 -> out_valid=0 immediately.
  - After release, a new matrix drains from row 0 correctly.

Source files
------------

// File: rtl/systolic_output_drain_if.sv
// Row-drain bus for systolic_output_drain: matrix capture channel in, row stream out.
// The master side (producer/consumer environment) faces the slave side (the drain block).
interface systolic_output_drain_if #(
  parameter int WIDTH          = 16,
  parameter int HIDDEN_SIZE    = 2,
  parameter int CONTEXT_LENGTH = 4
);
  localparam int ROW_W = (HIDDEN_SIZE > 1) ? $clog2(HIDDEN_SIZE) : 1;

  logic                                      y_valid;
  logic                                      y_ready;
  logic [HIDDEN_SIZE*CONTEXT_LENGTH*2*WIDTH-1:0] Y_in;
  logic [4:0]                                shift_amt;
  logic                                      out_valid;
  logic                                      out_ready;
  logic [CONTEXT_LENGTH*WIDTH-1:0]           out_data;
  logic [ROW_W-1:0]                          out_row;
  logic                                      out_last;
  logic                                      sat_flag;

  modport master (
    output y_valid, Y_in, shift_amt, out_ready,
    input  y_ready, out_valid, out_data, out_row, out_last, sat_flag
  );

  modport slave (
    input  y_valid, Y_in, shift_amt, out_ready,
    output y_ready, out_valid, out_data, out_row, out_last, sat_flag
  );
endinterface

// File: rtl/systolic_output_drain.sv
// Captures a full accumulator matrix, requantizes it to WIDTH bits on capture
// (rounding arithmetic shift + saturation) and streams it out one row per beat.
module systolic_output_drain #(
  parameter int WIDTH          = 16,
  parameter int HIDDEN_SIZE    = 2,
  parameter int CONTEXT_LENGTH = 4
) (
  input logic                  clock,
  input logic                  rst,
  systolic_output_drain_if.slave bus
);
  localparam int ROW_W = (HIDDEN_SIZE > 1) ? $clog2(HIDDEN_SIZE) : 1;
  localparam int ACC_W = 2 * WIDTH;
  // Wide enough for the sign bit plus the largest rounding bias (1 << 30).
  localparam int EXT_W = (ACC_W + 1 > 33) ? ACC_W + 1 : 33;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HIDDEN_SIZE - 1);

  typedef enum logic {IDLE, DRAIN} state_e;

  typedef logic [HIDDEN_SIZE-1:0][CONTEXT_LENGTH-1:0][WIDTH-1:0] qmat_t;

  state_e                 state_q, state_d;
  logic [ROW_W-1:0]       row_q, row_d;
  qmat_t                  buf_q, buf_d, quant;
  logic [HIDDEN_SIZE-1:0] sat_q, sat_d, quant_sat;

  logic out_valid, out_last, y_ready, capture, beat;

  function automatic logic [WIDTH-1:0] requantize(
    input  logic signed [ACC_W-1:0] x,
    input  logic [4:0]              s,
    output logic                    sat
  );
    logic signed [EXT_W-1:0] bias, sum, t;
    logic [EXT_W-WIDTH:0]    top;
    bias = (s == 5'd0) ? '0 : (EXT_W'(1) << (s - 5'd1));
    sum  = EXT_W'(x) + bias;
    t    = sum >>> s;
    // In range exactly when every bit from WIDTH-1 upward is a copy of the sign.
    top  = t[EXT_W-1:WIDTH-1];
    sat  = !((&top) || !(|top));
    if (!sat) return t[WIDTH-1:0];
    return t[EXT_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  always_comb begin
    quant     = '0;
    quant_sat = '0;
    for (int r = 0; r < HIDDEN_SIZE; r++) begin
      for (int c = 0; c < CONTEXT_LENGTH; c++) begin
        logic elem_sat;
        quant[r][c] = requantize(bus.Y_in[(r*CONTEXT_LENGTH+c)*ACC_W +: ACC_W],
                                 bus.shift_amt, elem_sat);
        quant_sat[r] = quant_sat[r] | elem_sat;
      end
    end
  end

  assign out_valid = (state_q == DRAIN);
  assign out_last  = out_valid && (row_q == LAST_ROW);
  assign beat      = out_valid && bus.out_ready;
  assign y_ready   = !rst && ((state_q == IDLE) || (beat && out_last));
  assign capture   = bus.y_valid && y_ready;

  assign bus.y_ready   = y_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out_row   = row_q;
  assign bus.out_data  = out_valid ? buf_q[row_q] : '0;
  assign bus.sat_flag  = out_valid && sat_q[row_q];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d = state_q;
    row_d   = row_q;
    buf_d   = buf_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = DRAIN;
          row_d   = '0;
        end
      end
      DRAIN: begin
        if (beat) begin
          if (out_last) begin
            row_d   = '0;
            state_d = capture ? DRAIN : IDLE;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      buf_d = quant;
      sat_d = quant_sat;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      // NOTE: the row buffer is small flop storage, so it is cleared on reset like any register.
      buf_q   <= '0;
      sat_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      buf_q   <= buf_d;
      sat_q   <= sat_d;
    end
  end
endmodule
